// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Depth and counter width are derived from WIDTH/DIGIT at elaboration time.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-step configuration still needs a one-bit counter.
    function automatic int cnt_bits(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit full subtractor: d = a - b - bi, borrow-out bo.
// Purely combinational, zero latency, no flow control.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor, diff = a - b - bin, DIGIT bits per clock, LSB first.
// Latency STEPS cycles start-to-done; start is only accepted in IDLE, never queued.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = cnt_bits(STEPS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   bc;
    logic [DIGIT-1:0] dig;
    logic [WIDTH-1:0] res_shift;

    assign bc[0] = brw_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fs_cell u_cell (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .bi (bc[i]),
            .d  (dig[i]),
            .bo (bc[i+1])
        );
    end

    // New digit enters at the top so the full result is aligned after STEPS shifts.
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_shift;
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                brw_d = bc[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    diff_d   = res_shift;
                    borrow_d = bc[DIGIT];
                    ovf_d    = (sa_q != sb_q) && (res_shift[WIDTH-1] != sa_q);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: drivers queue expected results, per-instance monitors check on done.
module tb_serial_sub;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        start4 = 1'b0, start1 = 1'b0, start16 = 1'b0, startw = 1'b0;
    logic        aw = 1'b0, bw = 1'b0, binw = 1'b0;

    logic        busy4, done4, brw4, ovf4;
    logic [15:0] diff4;
    logic        busy1, done1, brw1, ovf1;
    logic [15:0] diff1;
    logic        busy16, done16, brw16, ovf16;
    logic [15:0] diff16;
    logic        busyw, donew, brww, ovfw;
    logic [0:0]  diffw;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t q4[$], q1[$], q16[$], qw[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(16), .DIGIT(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(brw4), .overflow(ovf4));
    serial_sub #(.WIDTH(16), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(brw1), .overflow(ovf1));
    serial_sub #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .bin(bin),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(brw16), .overflow(ovf16));
    serial_sub #(.WIDTH(1), .DIGIT(1)) uw (
        .clk(clk), .rst(rst), .start(startw), .a(aw), .b(bw), .bin(binw),
        .busy(busyw), .done(donew), .diff(diffw), .borrow(brww), .overflow(ovfw));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [15:0] d,
                             input logic bo, input logic ov);
        chk({tag, "_diff"}, 32'(d), 32'(e.d));
        chk({tag, "_borrow"}, 32'(bo), 32'(e.bo));
        chk({tag, "_overflow"}, 32'(ov), 32'(e.ov));
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.due));
    endtask

    task automatic unexpected(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: done seen with no result pending at cycle %0d", tag, cyc);
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && done4) begin
            if (q4.size() == 0) unexpected("u4");
            else begin e = q4.pop_front(); check_out("u4", e, diff4, brw4, ovf4); end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) unexpected("u1");
            else begin e = q1.pop_front(); check_out("u1", e, diff1, brw1, ovf1); end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst && done16) begin
            if (q16.size() == 0) unexpected("u16");
            else begin e = q16.pop_front(); check_out("u16", e, diff16, brw16, ovf16); end
        end
    end

    always @(negedge clk) begin : monw
        exp_t e;
        if (!rst && donew) begin
            if (qw.size() == 0) unexpected("uw");
            else begin e = qw.pop_front(); check_out("uw", e, 16'(diffw), brww, ovfw); end
        end
    end

    function automatic exp_t ref_sub(input logic [15:0] x, input logic [15:0] y,
                                     input logic c, input int due);
        exp_t        r;
        logic [16:0] w;
        w     = {1'b0, x} - {1'b0, y} - {16'd0, c};
        r.d   = w[15:0];
        r.bo  = w[16];
        r.ov  = (x[15] != y[15]) && (w[15] != x[15]);
        r.due = due;
        return r;
    endfunction

    // Called at a negedge; start is taken at the next edge, done shows 4 edges later.
    task automatic issue4(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                          input logic [15:0] ed, input logic ebo, input logic eov);
        a = xa; b = xb; bin = xc; start4 = 1'b1;
        q4.push_back('{ed, ebo, eov, cyc + 5});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((q4.size() + q1.size() + q16.size() + qw.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending_results"}, 32'(q4.size() + q1.size() + q16.size() + qw.size()), 32'd0);
        q4.delete(); q1.delete(); q16.delete(); qw.delete();
    endtask

    // {diff, borrow, overflow} for (a,b,bin) = index bits [2:0]
    logic [2:0] tt [8] = '{3'b000, 3'b110, 3'b111, 3'b010, 3'b100, 3'b001, 3'b000, 3'b110};

    initial begin
        #1;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_diff", 32'(diff4), 32'd0);
        chk("rst_borrow", 32'(brw4), 32'd0);
        chk("rst_overflow", 32'(ovf4), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic: busy for 4 cycles, then a single-cycle done.
        issue4(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("basic_busy_run", 32'(busy4), 32'd1);
            @(negedge clk);
        end
        chk("basic_busy_done", 32'(busy4), 32'd0);
        chk("basic_done_high", 32'(done4), 32'd1);
        @(negedge clk);
        chk("basic_done_pulse", 32'(done4), 32'd0);
        wait_drain("basic", 20);

        issue4(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        wait_drain("underflow", 20);
        issue4(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        wait_drain("signed_ovf", 20);
        issue4(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
        wait_drain("borrow_in", 20);

        // Start held high: only edges where the FSM is IDLE take operands.
        begin
            int c0;
            c0 = cyc;
            start4 = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (i >= 6) chk("hold_diff_stable", 32'(diff4), 32'h0FFF);
                if (i == 0) begin
                    a = 16'h1000; b = 16'h0001; bin = 1'b0;
                    q4.push_back('{16'h0FFF, 1'b0, 1'b0, c0 + 5});
                end else if (i == 5) begin
                    a = 16'h7FFF; b = 16'hFFFF; bin = 1'b0;
                    q4.push_back('{16'h8000, 1'b1, 1'b1, c0 + 10});
                end else begin
                    a = 16'h5555 ^ 16'(i); b = 16'h1111; bin = 1'b1;
                end
                @(negedge clk);
            end
            start4 = 1'b0;
        end
        wait_drain("handshake", 20);

        // Reset two cycles into a run aborts it without a done pulse.
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_diff", 32'(diff4), 32'd0);
        chk("abort_borrow", 32'(brw4), 32'd0);
        chk("abort_overflow", 32'(ovf4), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done_diff", 32'(diff4), 32'd0);
        issue4(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
        wait_drain("post_abort", 20);

        // Single-bit configuration: full truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            logic [2:0] t;
            idx = 3'(i);
            t = tt[i];
            aw = idx[2]; bw = idx[1]; binw = idx[0]; startw = 1'b1;
            qw.push_back('{16'(t[2]), t[1], t[0], cyc + 2});
            @(negedge clk);
            startw = 1'b0;
            wait_drain("w1_table", 10);
        end

        // DIGIT=1 and DIGIT=16 side by side on random operands.
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (n == 0) begin a = 16'h0000; b = 16'hFFFF; bin = 1'b1; end
            start1 = 1'b1; start16 = 1'b1;
            q1.push_back(ref_sub(a, b, bin, cyc + 17));
            q16.push_back(ref_sub(a, b, bin, cyc + 2));
            @(negedge clk);
            start1 = 1'b0; start16 = 1'b0;
            wait_drain("sweep", 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
